// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between MEM stage and byte-masked data memory.
// Ports: i_req_* request handshake, o_resp_* response handshake, o_mem_*/i_mem_rdata memory side.
module lsu_ctrl #(
    parameter int MEM_BYTES     = 2048,
    parameter int MISALIGN_TRAP = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_func3,
    input  logic [15:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [2:0]  o_mem_func3,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask_align,
    output logic [3:0]  o_mem_bmask_misalign,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [16:0] LP_LIMIT = 17'(MEM_BYTES);
    localparam bit          LP_TRAP  = (MISALIGN_TRAP != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_func3;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_legal;
    logic [2:0]  w_size_m1;
    logic [16:0] w_last;
    logic        w_oob;
    logic        w_misalign;
    logic        w_req_err;
    logic [7:0]  w_base;
    logic [7:0]  w_lanes;

    // Request decode, evaluated on the incoming request in IDLE.
    always_comb begin
        w_legal = 1'b0;
        case (i_req_func3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~i_req_we;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_size_m1 = 3'd3;
        case (i_req_func3[1:0])
            2'b00:   w_size_m1 = 3'd0;
            2'b01:   w_size_m1 = 3'd1;
            default: w_size_m1 = 3'd3;
        endcase
    end

    // 17-bit sum so an access near 0xFFFF cannot wrap back in range.
    assign w_last     = {1'b0, i_req_addr} + {14'd0, w_size_m1};
    assign w_oob      = (w_last >= LP_LIMIT);
    assign w_misalign = ((i_req_func3[1:0] == 2'b01) & i_req_addr[0])
                      | ((i_req_func3[1:0] == 2'b10) & (i_req_addr[1:0] != 2'b00));
    assign w_req_err  = ~w_legal | w_oob | (LP_TRAP & w_misalign);

    // Byte lanes of the access, shifted by the offset; the upper
    // nibble spills into the following word.
    always_comb begin
        w_base = 8'h00;
        case (r_func3[1:0])
            2'b00:   w_base = 8'h01;
            2'b01:   w_base = 8'h03;
            2'b10:   w_base = 8'h0F;
            default: w_base = 8'h00;
        endcase
    end

    assign w_lanes = w_base << r_addr[1:0];

    always_comb begin
        w_next               = r_state;
        o_req_ready          = 1'b0;
        o_resp_valid         = 1'b0;
        o_mem_wren           = 1'b0;
        o_mem_rden           = 1'b0;
        o_mem_bmask_align    = 4'b0000;
        o_mem_bmask_misalign = 4'b0000;
        unique case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_next = w_req_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_bmask_align    = w_lanes[3:0];
                o_mem_bmask_misalign = w_lanes[7:4];
                if (r_we) begin
                    o_mem_wren = 1'b1;
                    w_next     = S_RESP;
                end else begin
                    o_mem_rden = 1'b1;
                    w_next     = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_func3 <= 3'd0;
            r_addr  <= 16'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req_valid) begin
                r_we    <= i_req_we;
                r_func3 <= i_req_func3;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_err   <= w_req_err;
                r_rdata <= 32'd0;
            end
            if (r_state == S_LOAD_WAIT) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;
    assign o_mem_func3  = r_func3;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a byte-level memory model.
// Drives directed loads/stores; a monitor pops expected responses on handshake.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_func3;
    logic [15:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic [2:0]  o_mem_func3;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask_align;
    logic [3:0]  o_mem_bmask_misalign;
    logic        o_mem_wren;
    logic        o_mem_rden;
    logic [31:0] i_mem_rdata;

    logic        t_valid;
    logic        t_ready;
    logic        t_we;
    logic [2:0]  t_func3;
    logic [15:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_resp_valid;
    logic        t_resp_ready;
    logic [31:0] t_resp_rdata;
    logic        t_resp_err;
    logic [2:0]  t_mem_func3;
    logic [15:0] t_mem_addr;
    logic [31:0] t_mem_wdata;
    logic [3:0]  t_align;
    logic [3:0]  t_misalign;
    logic        t_wren;
    logic        t_rden;
    logic [31:0] t_mem_rdata;

    lsu_ctrl #(.MEM_BYTES(2048), .MISALIGN_TRAP(0)) u_dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_func3(i_req_func3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_mem_func3(o_mem_func3), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask_align(o_mem_bmask_align),
        .o_mem_bmask_misalign(o_mem_bmask_misalign),
        .o_mem_wren(o_mem_wren), .o_mem_rden(o_mem_rden),
        .i_mem_rdata(i_mem_rdata)
    );

    lsu_ctrl #(.MEM_BYTES(2048), .MISALIGN_TRAP(1)) u_trap (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(t_valid), .o_req_ready(t_ready),
        .i_req_we(t_we), .i_req_func3(t_func3),
        .i_req_addr(t_addr), .i_req_wdata(t_wdata),
        .o_resp_valid(t_resp_valid), .i_resp_ready(t_resp_ready),
        .o_resp_rdata(t_resp_rdata), .o_resp_err(t_resp_err),
        .o_mem_func3(t_mem_func3), .o_mem_addr(t_mem_addr),
        .o_mem_wdata(t_mem_wdata),
        .o_mem_bmask_align(t_align),
        .o_mem_bmask_misalign(t_misalign),
        .o_mem_wren(t_wren), .o_mem_rden(t_rden),
        .i_mem_rdata(t_mem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int cnt_wr  = 0;
    int cnt_rd  = 0;
    bit started = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-addressed memory model driven by the DUT masks.
    logic [7:0] mem [int];

    function automatic logic [7:0] rdb(input int a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin : mem_model
        int          base;
        int          k;
        logic [7:0]  b [4];
        logic [31:0] w;
        base = {16'd0, o_mem_addr[15:2], 2'b00};
        if (o_mem_wren) begin
            for (int j = 0; j < 4; j++) begin
                if (o_mem_bmask_align[j]) begin
                    k = base + j - int'(o_mem_addr);
                    if (k >= 0 && k < 4) mem[base + j] = o_mem_wdata[8*k +: 8];
                end
                if (o_mem_bmask_misalign[j]) begin
                    k = base + 4 + j - int'(o_mem_addr);
                    if (k >= 0 && k < 4) mem[base + 4 + j] = o_mem_wdata[8*k +: 8];
                end
            end
        end
        if (o_mem_rden) begin
            for (int j = 0; j < 4; j++) b[j] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                if (o_mem_bmask_align[j]) begin
                    k = base + j - int'(o_mem_addr);
                    if (k >= 0 && k < 4) b[k] = rdb(base + j);
                end
                if (o_mem_bmask_misalign[j]) begin
                    k = base + 4 + j - int'(o_mem_addr);
                    if (k >= 0 && k < 4) b[k] = rdb(base + 4 + j);
                end
            end
            case (o_mem_func3)
                3'b000:  w = {{24{b[0][7]}}, b[0]};
                3'b001:  w = {{16{b[1][7]}}, b[1], b[0]};
                3'b100:  w = {24'd0, b[0]};
                3'b101:  w = {16'd0, b[1], b[0]};
                default: w = {b[3], b[2], b[1], b[0]};
            endcase
            i_mem_rdata <= w;
        end
    end

    // Strobe counters and masks-quiet-when-idle check.
    initial forever begin
        @(negedge clk);
        if (started && !i_reset) begin
            if (o_mem_wren) cnt_wr++;
            if (o_mem_rden) cnt_rd++;
            if (!o_mem_wren && !o_mem_rden)
                chk("idle_mask",
                    {24'd0, o_mem_bmask_align, o_mem_bmask_misalign}, 32'd0);
        end
    end

    // Response monitor: checks latency on the first valid cycle and
    // pops/compares on the handshake cycle.
    initial begin : monitor
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (started && !i_reset && o_resp_valid) begin
                if (!prev_v) begin
                    if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                    else chk("latency", cyc - sb[0].acc, sb[0].lat);
                end
                if (i_resp_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_rdata", o_resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, o_resp_err}, {31'd0, e.err});
                end
            end
            prev_v = started && !i_reset && o_resp_valid;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [15:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee,
                         input logic [3:0] ea, input logic [3:0] em);
        exp_t e;
        bit   ok;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_func3 = f3;
        i_req_addr  = a;
        i_req_wdata = wd;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        e.rdata = er;
        e.err   = ee;
        e.acc   = cyc;
        e.lat   = ee ? 1 : (we ? 2 : 3);
        sb.push_back(e);
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        if (!ee) begin
            @(negedge clk);
            chk("issue_wren", {31'd0, o_mem_wren}, {31'd0, we});
            chk("issue_rden", {31'd0, o_mem_rden}, {31'd0, ~we});
            chk("issue_align", {28'd0, o_mem_bmask_align}, {28'd0, ea});
            chk("issue_misalign", {28'd0, o_mem_bmask_misalign}, {28'd0, em});
            chk("issue_addr", {16'd0, o_mem_addr}, {16'd0, a});
            chk("issue_func3", {29'd0, o_mem_func3}, {29'd0, f3});
            if (we) chk("issue_wdata", o_mem_wdata, wd);
        end
    endtask

    task automatic drain(input int w0, input int r0,
                         input logic we, input logic ee);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end else begin
            chk("ready_after_resp", {31'd0, o_req_ready}, 32'd1);
        end
        chk("wren_count", cnt_wr - w0, (!ee && we) ? 32'd1 : 32'd0);
        chk("rden_count", cnt_rd - r0, (!ee && !we) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic we, input logic [2:0] f3,
                      input logic [15:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee,
                      input logic [3:0] ea, input logic [3:0] em);
        int w0;
        int r0;
        w0 = cnt_wr;
        r0 = cnt_rd;
        issue(we, f3, a, wd, er, ee, ea, em);
        drain(w0, r0, we, ee);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, o_resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, o_resp_err}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, o_mem_wren, o_mem_rden}, 32'd0);
        chk({tag, "_masks"},
            {24'd0, o_mem_bmask_align, o_mem_bmask_misalign}, 32'd0);
        chk({tag, "_mem_addr"}, {16'd0, o_mem_addr}, 32'd0);
        chk({tag, "_mem_func3"}, {29'd0, o_mem_func3}, 32'd0);
        chk({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    endtask

    task automatic trap_accept(input logic [2:0] f3, input logic [15:0] a);
        bit ok;
        t_valid = 1'b1;
        t_we    = 1'b0;
        t_func3 = f3;
        t_addr  = a;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (t_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("trap_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 t_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_func3  = 3'd0;
        i_req_addr   = 16'd0;
        i_req_wdata  = 32'd0;
        i_resp_ready = 1'b1;
        i_mem_rdata  = 32'd0;
        t_valid      = 1'b0;
        t_we         = 1'b0;
        t_func3      = 3'd0;
        t_addr       = 16'd0;
        t_wdata      = 32'd0;
        t_resp_ready = 1'b1;
        t_mem_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;
        started = 1'b1;
        @(negedge clk);
        chk_zero_outputs("reset");
        chk("trap_reset_ready", {31'd0, t_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Aligned and misaligned stores/loads.
        op(1, 3'b010, 16'h0010, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 4'b0000);
        op(1, 3'b010, 16'h0008, 32'h11223344, 32'h0, 0, 4'b1111, 4'b0000);
        op(1, 3'b010, 16'h000C, 32'h55667788, 32'h0, 0, 4'b1111, 4'b0000);
        op(0, 3'b010, 16'h000A, 32'h0, 32'h77881122, 0, 4'b1100, 4'b0011);
        op(1, 3'b001, 16'h0007, 32'h0000ABCD, 32'h0, 0, 4'b1000, 4'b0001);
        op(0, 3'b101, 16'h0007, 32'h0, 32'h0000ABCD, 0, 4'b1000, 4'b0001);
        op(0, 3'b000, 16'h0008, 32'h0, 32'hFFFFFFAB, 0, 4'b0001, 4'b0000);
        op(0, 3'b100, 16'h0011, 32'h0, 32'h000000BE, 0, 4'b0010, 4'b0000);
        op(0, 3'b001, 16'h0012, 32'h0, 32'hFFFFDEAD, 0, 4'b1100, 4'b0000);

        // Errors: illegal func3 and out-of-range.
        op(0, 3'b011, 16'h0000, 32'h0, 32'h0, 1, 4'b0000, 4'b0000);
        op(1, 3'b100, 16'h0000, 32'h12345678, 32'h0, 1, 4'b0000, 4'b0000);
        op(0, 3'b010, 16'h07FE, 32'h0, 32'h0, 1, 4'b0000, 4'b0000);
        op(0, 3'b001, 16'h07FF, 32'h0, 32'h0, 1, 4'b0000, 4'b0000);
        op(0, 3'b000, 16'h0800, 32'h0, 32'h0, 1, 4'b0000, 4'b0000);

        // Last legal bytes of memory.
        op(0, 3'b010, 16'h07FC, 32'h0, 32'h0, 0, 4'b1111, 4'b0000);
        op(1, 3'b000, 16'h07FF, 32'h0000005A, 32'h0, 0, 4'b1000, 4'b0000);
        op(0, 3'b100, 16'h07FF, 32'h0, 32'h0000005A, 0, 4'b1000, 4'b0000);

        // Backpressure on an LB.
        begin : backpressure
            int w0;
            int r0;
            bit ok;
            w0 = cnt_wr;
            r0 = cnt_rd;
            i_resp_ready = 1'b0;
            issue(0, 3'b000, 16'h0010, 32'h0, 32'hFFFFFFEF, 0,
                  4'b0001, 4'b0000);
            ok = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (o_resp_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("bp_valid_timeout", 32'd0, 32'd1);
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                chk("bp_valid", {31'd0, o_resp_valid}, 32'd1);
                chk("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
                chk("bp_rdata", o_resp_rdata, 32'hFFFFFFEF);
                chk("bp_err", {31'd0, o_resp_err}, 32'd0);
            end
            @(posedge clk);
            #1 i_resp_ready = 1'b1;
            drain(w0, r0, 0, 0);
        end

        // Reset while waiting for load data.
        issue(0, 3'b010, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 4'b0000);
        @(posedge clk);
        #1 i_reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midload_reset");
        @(negedge clk);
        chk("post_reset_valid", {31'd0, o_resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        op(0, 3'b010, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 4'b0000);

        // Trapping instance: misaligned LH errors, aligned LW issues.
        trap_accept(3'b001, 16'h0001);
        @(negedge clk);
        chk("trap_lh_valid", {31'd0, t_resp_valid}, 32'd1);
        chk("trap_lh_err", {31'd0, t_resp_err}, 32'd1);
        chk("trap_lh_strobes", {30'd0, t_wren, t_rden}, 32'd0);
        @(posedge clk);
        #1;
        trap_accept(3'b010, 16'h0004);
        @(negedge clk);
        chk("trap_lw_rden", {31'd0, t_rden}, 32'd1);
        chk("trap_lw_valid", {31'd0, t_resp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("trap_lw_resp", {31'd0, t_resp_valid}, 32'd1);
        chk("trap_lw_err", {31'd0, t_resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
